// File: rtl/arb_rr_weighted_ack_pkg.sv
// rtl/arb_rr_weighted_ack_pkg.sv - shared helpers for the weighted round-robin arbiter
package arb_rr_weighted_ack_pkg;

  // Binary index width for a requester count, never narrower than one bit.
  function automatic int id_width(input int clients);
    return (clients > 2) ? $clog2(clients) : 1;
  endfunction

endpackage

// File: rtl/arb_fixed_priority.sv
// rtl/arb_fixed_priority.sv - combinational LSB-first fixed-priority one-hot picker
module arb_fixed_priority #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] req,
  output logic [WIDTH-1:0] gnt
);

  // Two's-complement trick isolates the lowest set bit.
  assign gnt = req & (~req + WIDTH'(1));

endmodule

// File: rtl/arb_rr_weighted_ack.sv
// rtl/arb_rr_weighted_ack.sv - weighted masked round-robin arbiter with optional grant handshake
module arb_rr_weighted_ack
  import arb_rr_weighted_ack_pkg::*;
#(
  parameter int CLIENTS      = 4,
  parameter bit WAIT_GNT_ACK = 1'b1,
  parameter int WEIGHT_W     = 4,
  localparam int ID_W        = id_width(CLIENTS)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         block_arb,
  input  logic [CLIENTS-1:0]           req,
  input  logic [CLIENTS*WEIGHT_W-1:0]  cfg_weight,
  input  logic                         grant_ack,
  output logic                         grant_valid,
  output logic [CLIENTS-1:0]           grant,
  output logic [ID_W-1:0]              grant_id
);

  logic                grant_valid_q, grant_valid_d;
  logic [CLIENTS-1:0]  grant_q, grant_d;
  logic [ID_W-1:0]     grant_id_q, grant_id_d;
  logic [ID_W-1:0]     ptr_q, ptr_d;
  logic [ID_W-1:0]     last_q, last_d;
  logic [WEIGHT_W-1:0] credit_q, credit_d;

  logic                complete, hold, load;
  logic [WEIGHT_W-1:0] w_done, w_last;
  logic [CLIENTS-1:0]  mask, req_masked, gnt_masked, gnt_raw, sel;
  logic [ID_W-1:0]     sel_id;

  function automatic logic [WEIGHT_W-1:0] weight_of(
    input logic [ID_W-1:0]             id,
    input logic [CLIENTS*WEIGHT_W-1:0] cfg
  );
    logic [WEIGHT_W-1:0] w;
    w = cfg[int'(id)*WEIGHT_W +: WEIGHT_W];
    return (w == '0) ? WEIGHT_W'(1) : w;
  endfunction

  assign complete = grant_valid_q & (WAIT_GNT_ACK ? grant_ack : 1'b1);

  // Pointer/credit move only when a grant completes.
  always_comb begin
    ptr_d    = ptr_q;
    last_d   = last_q;
    credit_d = credit_q;
    w_done   = weight_of(grant_id_q, cfg_weight);
    if (complete) begin
      last_d = grant_id_q;
      if (grant_id_q == last_q && credit_q != '0 && credit_q < w_done) begin
        credit_d = credit_q + WEIGHT_W'(1);
      end else begin
        credit_d = WEIGHT_W'(1);
      end
      if (credit_d >= w_done) begin
        ptr_d = grant_id_q;
      end
    end
  end

  // Arbitrate on post-completion state so back-to-back grants see fresh credit.
  always_comb begin
    mask = '0;
    for (int i = 0; i < CLIENTS; i++) begin
      mask[i] = (i > int'(ptr_d));
    end
  end

  assign req_masked = req & mask;

  arb_fixed_priority #(.WIDTH(CLIENTS)) u_fp_masked (
    .req (req_masked),
    .gnt (gnt_masked)
  );

  arb_fixed_priority #(.WIDTH(CLIENTS)) u_fp_raw (
    .req (req),
    .gnt (gnt_raw)
  );

  assign w_last = weight_of(last_d, cfg_weight);
  assign hold   = req[last_d] && (credit_d != '0) && (credit_d < w_last);

  always_comb begin
    sel_id = '0;
    if (hold) begin
      sel = CLIENTS'(1) << last_d;
    end else if (|req_masked) begin
      sel = gnt_masked;
    end else begin
      sel = gnt_raw;
    end
    for (int i = 0; i < CLIENTS; i++) begin
      if (sel[i]) sel_id = ID_W'(i);
    end
  end

  assign load = (~grant_valid_q | complete) & ~block_arb & (|req);

  always_comb begin
    grant_d       = grant_q;
    grant_id_d    = grant_id_q;
    grant_valid_d = grant_valid_q;
    if (load) begin
      grant_d       = sel;
      grant_id_d    = sel_id;
      grant_valid_d = 1'b1;
    end else if (complete) begin
      grant_d       = '0;
      grant_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_valid_q <= 1'b0;
      grant_q       <= '0;
      grant_id_q    <= '0;
      ptr_q         <= ID_W'(CLIENTS - 1);
      last_q        <= '0;
      credit_q      <= '0;
    end else begin
      grant_valid_q <= grant_valid_d;
      grant_q       <= grant_d;
      grant_id_q    <= grant_id_d;
      ptr_q         <= ptr_d;
      last_q        <= last_d;
      credit_q      <= credit_d;
    end
  end

  assign grant_valid = grant_valid_q;
  assign grant       = grant_q;
  assign grant_id    = grant_id_q;

endmodule
